// File: rtl/poly_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : poly_io_ctrl
// Purpose  : Host-side initiator for the multi-lane NTT core. Streams N
//            coefficients into the banks using the skewed stage-0 mapping,
//            pulses the core start with the latched opcode, waits for finish,
//            then streams the N results out through a 2-entry skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module poly_io_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int N          = 256,
    parameter int BANKS      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,         // asynchronous, active low
    input  logic                     go,
    input  logic [1:0]               op_in,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     bank_we,
    output logic                     bank_re,
    output logic [$clog2(BANKS)-1:0] bank_sel,
    output logic [ADDR_WIDTH-1:0]    bank_addr,
    output logic [DATA_WIDTH-1:0]    bank_wdata,
    input  logic [DATA_WIDTH-1:0]    bank_rdata,
    output logic                     ntt_start,
    output logic [1:0]               ntt_opcode,
    input  logic                     ntt_finish,
    output logic                     busy,
    output logic                     done
);

    localparam int SEL_W = $clog2(BANKS);
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] C_N        = CNT_W'(N);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       idx_q, idx_d;        // load index, then read-issue index
    logic [CNT_W-1:0]       pop_q, pop_d;        // results handed off to the sink
    logic [1:0]             op_q, op_d;
    logic                   inflight_q, inflight_d;
    logic                   done_q, done_d;
    logic [DATA_WIDTH-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
    logic                   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;

    logic [CNT_W-1:0]       map_addr;
    logic [SEL_W-1:0]       map_sel;
    logic                   push, pop, issue_ok;
    logic [2:0]             pending;

    // Skewed mapping of the current index: addr = idx/BANKS, sel = (idx + addr) mod BANKS
    always_comb begin
        map_addr = idx_q >> SEL_W;
        map_sel  = idx_q[SEL_W-1:0] + map_addr[SEL_W-1:0];
    end

    // FIFO handshake terms; a same-cycle pop frees a slot so reads can stream at one per cycle
    always_comb begin
        push     = inflight_q;
        pop      = m_valid && m_ready;
        pending  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue_ok = (pending < 3'd2) && (idx_q < C_N);
    end

    // Sequencer: next state, counters and bank port strobes
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pop_d      = pop_q;
        op_d       = op_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        s_ready    = 1'b0;
        bank_we    = 1'b0;
        bank_re    = 1'b0;
        bank_sel   = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    op_d    = op_in;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    bank_we    = 1'b1;
                    bank_sel   = map_sel;
                    bank_addr  = ADDR_WIDTH'(map_addr);
                    bank_wdata = s_data;
                    idx_d      = idx_q + C_ONE;
                    if (idx_q == C_LAST_IDX) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ntt_finish) begin
                    idx_d   = '0;
                    pop_d   = '0;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (issue_ok) begin
                    bank_re    = 1'b1;
                    bank_sel   = map_sel;
                    bank_addr  = ADDR_WIDTH'(map_addr);
                    idx_d      = idx_q + C_ONE;
                    inflight_d = 1'b1;
                end
                if (pop) begin
                    pop_d = pop_q + C_ONE;
                    if (pop_q == C_LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Skid FIFO: capture read data one cycle after the strobe, pop on sink handshake
    always_comb begin
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            if (wr_ptr_q) begin
                ent1_d = bank_rdata;
            end else begin
                ent0_d = bank_rdata;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State and datapath registers; reset discards any in-flight reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            pop_q      <= '0;
            op_q       <= 2'b00;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pop_q      <= pop_d;
            op_q       <= op_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        m_valid    = (count_q != 2'd0);
        m_data     = m_valid ? (rd_ptr_q ? ent1_q : ent0_q) : '0;
        ntt_start  = (state_q == ST_START);
        ntt_opcode = op_q;
        busy       = (state_q != ST_IDLE);
        done       = done_q;
    end

endmodule
`default_nettype wire
